// File: rtl/rr_grant_arbiter_4.sv
// rr_grant_arbiter_4: four-client round-robin arbiter with a bounded hold time.
// The winner is registered as a 2-bit index and also presented as a one-hot
// grant vector, so it can drive one-hot select lines directly.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   en_i           arbitration enable; low forces release of any grant
//   req_i[3:0]     request vector, bit i = client i
//   grant_o[3:0]   registered one-hot grant, 0000 when nobody owns the resource
//   grant_idx_o    registered owner index, meaningful only while grant_valid_o=1
//   grant_valid_o  registered, high while a grant is active
module rr_grant_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] req_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_valid_o
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // 2-to-4 decode of an owner index into a one-hot select.
  function automatic logic [N_REQ-1:0] dec2to4(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // Round-robin search starting just after 'base': returns {found, index}.
  // Candidates are visited last-priority first so the highest-priority hit
  // overwrites earlier ones.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDX_W-1:0] base);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'(base + IDX_W'(k));
      if (mask[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0] last_q, last_d;

  logic [IDX_W:0]   pick_all_c;
  logic [IDX_W:0]   pick_oth_c;
  logic [N_REQ-1:0] others_c;
  logic             release_c;

  // Search results: from idle over all requests; while granted, over the others.
  always_comb begin
    others_c   = req_i & ~dec2to4(grant_idx_q);
    pick_all_c = rr_pick(req_i, last_q);
    pick_oth_c = rr_pick(others_c, grant_idx_q);
    release_c  = !en_i
               || !req_i[grant_idx_q]
               || ((hold_cnt_q == HOLD_MAX) && (|others_c));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    hold_cnt_d    = hold_cnt_q;
    last_d        = last_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_i && pick_all_c[IDX_W]) begin
          state_d       = ST_GRANT;
          grant_idx_d   = pick_all_c[IDX_W-1:0];
          grant_valid_d = 1'b1;
          hold_cnt_d    = HOLD_ONE;
          last_d        = pick_all_c[IDX_W-1:0];
        end
      end

      ST_GRANT: begin
        if (release_c) begin
          if (en_i && pick_oth_c[IDX_W]) begin
            // Hand over directly to the next client without an idle bubble.
            grant_idx_d   = pick_oth_c[IDX_W-1:0];
            grant_valid_d = 1'b1;
            hold_cnt_d    = HOLD_ONE;
            last_d        = pick_oth_c[IDX_W-1:0];
          end else begin
            // Pointer (last) is retained so fairness survives an idle period.
            state_d       = ST_IDLE;
            grant_valid_d = 1'b0;
            hold_cnt_d    = '0;
          end
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        hold_cnt_d    = '0;
      end
    endcase

    grant_d = grant_valid_d ? dec2to4(grant_idx_d) : '0;
  end

  // State and output registers; last resets to 3 so client 0 is searched first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      hold_cnt_q    <= '0;
      last_q        <= IDX_W'(N_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      hold_cnt_q    <= hold_cnt_d;
      last_q        <= last_d;
    end
  end

  // Grant vector must stay consistent with the encoded owner.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($onehot0(grant_q));
      assert (grant_q == (grant_valid_q ? dec2to4(grant_idx_q) : 4'b0000));
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// tb_rr_grant_arbiter_4: vector table plus hand-written fairness sequences.
module tb_rr_grant_arbiter_4;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk;
  logic       rst_i;
  logic       en_i;
  logic [3:0] req_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_valid_o;

  rr_grant_arbiter_4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .req_i        (req_i),
    .grant_o      (grant_o),
    .grant_idx_o  (grant_idx_o),
    .grant_valid_o(grant_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_no = 0;

  function automatic vec_t mk(input logic rst, input logic en, input logic [3:0] req,
                              input logic [3:0] g, input logic [1:0] idx, input logic v);
    vec_t r;
    r.rst = rst; r.en = en; r.req = req; r.g = g; r.idx = idx; r.v = v;
    return r;
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", nm, vec_no, act, exp);
    end
  endtask

  // Drive one vector, push its expectation, compare after the following edge.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst_i = v.rst;
    en_i  = v.en;
    req_i = v.req;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("grant", 8'(grant_o), 8'(e.g));
    check("valid", 8'(grant_valid_o), 8'(e.v));
    if (e.v) check("idx", 8'(grant_idx_o), 8'(e.idx));
    check("consistency", 8'(grant_o),
          8'(grant_valid_o ? (4'b0001 << grant_idx_o) : 4'b0000));
    vec_no++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    rst_i = 1'b1;
    en_i  = 1'b0;
    req_i = 4'b0000;

    // Reset, first grant
    vecs.push_back(mk(1, 0, 4'b1111, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'b0001, 4'b0001, 2'd0, 1));
    // All requesting: four cycles each, then wrap back to 0
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 4'b1111, 4'b0001, 2'd0, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 4'b1111, 4'b0010, 2'd1, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 4'b1111, 4'b0100, 2'd2, 1));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 1, 4'b1111, 4'b1000, 2'd3, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b0001, 2'd0, 1));
    // Sole requester keeps the grant past the hold limit
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 1, 4'b0100, 4'b0100, 2'd2, 1));
    // Owner drop hands over without a bubble
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0001, 2'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0011, 4'b0001, 2'd0, 1));
    vecs.push_back(mk(0, 1, 4'b0010, 4'b0010, 2'd1, 1));
    // Enable drop releases; pointer retained
    vecs.push_back(mk(0, 0, 4'b0010, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b0100, 2'd2, 1));
    // Reset mid-hold resets the pointer
    vecs.push_back(mk(0, 1, 4'b1111, 4'b0100, 2'd2, 1));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 4'b0001, 2'd0, 1));
    // No requests / disabled while idle
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'b0000, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 0, 4'b1111, 4'b0000, 2'd0, 0));
    vecs.push_back(mk(0, 1, 4'b1000, 4'b1000, 2'd3, 1));

    foreach (vecs[i]) step(vecs[i]);

    // Saturated hold counter: a late second requester takes over immediately
    step(mk(0, 1, 4'b0001, 4'b0001, 2'd0, 1));
    for (int i = 0; i < 4; i++) step(mk(0, 1, 4'b0001, 4'b0001, 2'd0, 1));
    step(mk(0, 1, 4'b0011, 4'b0010, 2'd1, 1));

    // Worst-position waiter: client 0 behind owner 1 with everyone requesting
    @(negedge clk);
    req_i  = 4'b1111;
    en_i   = 1'b1;
    waited = 0;
    for (int c = 1; c <= 3 * MAX_HOLD + 1; c++) begin
      @(posedge clk);
      #1;
      if (grant_o == 4'b0001) begin
        waited = c;
        break;
      end
    end
    check("fair_wait_found", 8'(waited != 0), 8'(1));
    check("fair_wait_cycles", 8'(waited), 8'(3 + 2 * MAX_HOLD + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
